pipeline_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS-DLX core. It generates the per-cycle enable and flush strobes for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline latches. It resolves load-use stalls, taken-branch flushes, multi-cycle data-memory waits and the halt/drain sequence. It sits beside the datapath and drives only latch controls, never data.

---
 rtl/dlx_pipe_pkg.sv | 33 +++
 rtl/hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dlx_pipe_pkg.sv
// Shared types and defaults for the DLX pipeline sequencing controller.
package dlx_pipe_pkg;

   localparam int REG_IDX_W        = 5;
   localparam int DEF_DRAIN_CYCLES = 3;
   localparam int DEF_MEM_TIMEOUT  = 255;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_HALTED   = 2'd3
   } pipe_state_t;

   // One bundle of latch controls so the strobe mux can pick whole patterns.
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
   } strobe_t;

   localparam strobe_t STRB_FREEZE = 7'b00000_00;
   localparam strobe_t STRB_RESET  = 7'b00000_11;
   localparam strobe_t STRB_RUN    = 7'b11111_00;
   localparam strobe_t STRB_BRANCH = 7'b11111_10;
   // Hold PC/IF_ID, push a bubble into ID_EX, let older work drain.
   localparam strobe_t STRB_BUBBLE = 7'b00111_01;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
module hazard_detect
   import dlx_pipe_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_uses_rt,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] ex_rw,
   output logic                 load_use
);

   // r0 is hardwired zero, so a load targeting it never creates a dependence.
   assign load_use = ex_mem_read && (ex_rw != '0) &&
                     ((ex_rw == id_rs) || (id_uses_rt && (ex_rw == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: latch enables/flushes for PC and the four
// pipeline latches, covering load-use stalls, branch flushes, memory waits
// and the halt/drain sequence.
module pipeline_ctrl
   import dlx_pipe_pkg::*;
#(
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_uses_rt,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] ex_rw,
   input  logic                 branch_taken,
   input  logic                 halt_req,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   output logic                 pc_en,
   output logic                 if_id_en,
   output logic                 id_ex_en,
   output logic                 ex_mem_en,
   output logic                 mem_wb_en,
   output logic                 if_id_flush,
   output logic                 id_ex_flush,
   output logic                 halted,
   output logic                 mem_timeout,
   output logic [15:0]          stall_count
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
   localparam logic [WW-1:0] TMO_LIMIT  = WW'(MEM_TIMEOUT);

   pipe_state_t   state, state_nxt;
   logic [DW-1:0] drain_cnt, drain_nxt;
   logic [WW-1:0] wait_cnt, wait_nxt;
   logic          tmo_set;
   logic          load_use;
   logic          mem_stall;
   strobe_t       strb;

   hazard_detect u_hazard (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rw       (ex_rw),
      .load_use    (load_use)
   );

   assign mem_stall = mem_req && !mem_ready;

   // Strobe mux and next-state/counter logic; reset overrides the strobes.
   always_comb begin
      strb      = STRB_FREEZE;
      state_nxt = state;
      drain_nxt = drain_cnt;
      wait_nxt  = wait_cnt;
      tmo_set   = 1'b0;
      case (state)
         ST_RUN: begin
            if (mem_stall) begin
               state_nxt = ST_MEM_WAIT;
            end else if (load_use) begin
               strb = STRB_BUBBLE;
            end else if (halt_req) begin
               strb      = STRB_BUBBLE;
               drain_nxt = DRAIN_LOAD;
               state_nxt = ST_DRAIN;
            end else if (branch_taken) begin
               strb = STRB_BRANCH;
            end else begin
               strb = STRB_RUN;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready) begin
               strb      = STRB_RUN;
               wait_nxt  = '0;
               state_nxt = ST_RUN;
            end else begin
               if (wait_cnt != '1) wait_nxt = wait_cnt + 1'b1;
               if (wait_nxt >= TMO_LIMIT) tmo_set = 1'b1;
            end
         end
         ST_DRAIN: begin
            // A memory wait freezes everything and holds the drain count.
            if (!mem_stall) begin
               strb = STRB_BUBBLE;
               if (drain_cnt == '0) state_nxt = ST_HALTED;
               else                 drain_nxt = drain_cnt - 1'b1;
            end
         end
         ST_HALTED: ;
         default: ;
      endcase
      if (reset) strb = STRB_RESET;
   end

   assign pc_en       = strb.pc_en;
   assign if_id_en    = strb.if_id_en;
   assign id_ex_en    = strb.id_ex_en;
   assign ex_mem_en   = strb.ex_mem_en;
   assign mem_wb_en   = strb.mem_wb_en;
   assign if_id_flush = strb.if_id_flush;
   assign id_ex_flush = strb.id_ex_flush;

   // Registered state, counters and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_RUN;
         drain_cnt   <= '0;
         wait_cnt    <= '0;
         halted      <= 1'b0;
         mem_timeout <= 1'b0;
         stall_count <= '0;
      end else begin
         state       <= state_nxt;
         drain_cnt   <= drain_nxt;
         wait_cnt    <= wait_nxt;
         halted      <= (state_nxt == ST_HALTED);
         mem_timeout <= mem_timeout | tmo_set;
         if (state != ST_HALTED && !strb.pc_en && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with default parameters.
module tb_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rw;
   logic       id_uses_rt, ex_mem_read, branch_taken, halt_req, mem_req, mem_ready;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
   logic       halted, mem_timeout;
   logic [15:0] stall_count;

   int checks = 0;
   int failures = 0;

   // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush, id_ex_flush}
   localparam logic [31:0] E_ALL = 32'b11111_00;
   localparam logic [31:0] E_BR  = 32'b11111_10;
   localparam logic [31:0] E_BUB = 32'b00111_01;
   localparam logic [31:0] E_FRZ = 32'b00000_00;
   localparam logic [31:0] E_RST = 32'b00000_11;

   pipeline_ctrl dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rw(ex_rw), .branch_taken(branch_taken),
      .halt_req(halt_req), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .halted(halted), .mem_timeout(mem_timeout), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] strb();
      return {25'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then settle inputs/outputs 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs = 0; id_rt = 0; ex_rw = 0; id_uses_rt = 0; ex_mem_read = 0;
      branch_taken = 0; halt_req = 0; mem_req = 0; mem_ready = 0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #1;
      chk("rst_strobes", strb(), E_RST);
      step(); step();
      chk("rst_strobes_hold", strb(), E_RST);
      reset = 1'b0;
      #1;
      chk("post_rst_strobes", strb(), E_ALL);
      chk("post_rst_halted", {31'd0, halted}, 32'd0);
      chk("post_rst_tmo", {31'd0, mem_timeout}, 32'd0);
      chk("post_rst_stall", {16'd0, stall_count}, 32'd0);

      // Load-use on rs
      ex_mem_read = 1; ex_rw = 5; id_rs = 5; #1;
      chk("lu_rs", strb(), E_BUB);
      step(); idle(); #1;
      chk("lu_rs_after", strb(), E_ALL);
      chk("lu_stall_cnt", {16'd0, stall_count}, 32'd1);
      // Load into r0: no hazard
      ex_mem_read = 1; ex_rw = 0; id_rs = 0; #1;
      chk("lu_r0", strb(), E_ALL);
      // rt hazard only when rt is used
      ex_rw = 7; id_rt = 7; id_rs = 3; id_uses_rt = 1; #1;
      chk("lu_rt_used", strb(), E_BUB);
      id_uses_rt = 0; #1;
      chk("lu_rt_unused", strb(), E_ALL);
      idle(); step();

      // Branch, then branch masked by hazard
      branch_taken = 1; #1;
      chk("branch", strb(), E_BR);
      ex_mem_read = 1; ex_rw = 5; id_rs = 5; #1;
      chk("branch_lu", strb(), E_BUB);
      step(); idle(); #1;
      chk("branch_lu_cnt", {16'd0, stall_count}, 32'd2);

      // Memory wait: 4 frozen cycles, then ready
      mem_req = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("memwait_%0d", i), strb(), E_FRZ);
         step();
      end
      mem_ready = 1; #1;
      chk("memwait_ready", strb(), E_ALL);
      step(); idle(); #1;
      chk("memwait_run", strb(), E_ALL);
      chk("memwait_cnt", {16'd0, stall_count}, 32'd6);

      // Halt with default drain
      halt_req = 1; #1;
      chk("halt_req", strb(), E_BUB);
      step(); halt_req = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("drain_%0d", i), strb(), E_BUB);
         chk($sformatf("drain_halted_%0d", i), {31'd0, halted}, 32'd0);
         step();
      end
      chk("halted", {31'd0, halted}, 32'd1);
      chk("halted_strb", strb(), E_FRZ);
      chk("halt_cnt", {16'd0, stall_count}, 32'd10);
      halt_req = 1; branch_taken = 1; step(); idle(); #1;
      chk("halted_stays", {31'd0, halted}, 32'd1);
      chk("halted_cnt_frozen", {16'd0, stall_count}, 32'd10);

      // Reset out of HALTED
      reset = 1; #1;
      chk("rst_in_halted", strb(), E_RST);
      step(); reset = 0; #1;
      chk("rst_halted_clear", {31'd0, halted}, 32'd0);

      // Halt with a 2-cycle memory wait inside drain
      halt_req = 1; step(); halt_req = 0;
      step();                      // drain count 2 -> 1
      mem_req = 1; #1;
      chk("drain_memwait", strb(), E_FRZ);
      step(); step(); mem_req = 0; #1;
      chk("drain_resume", strb(), E_BUB);
      step(); #1;
      chk("drain_last_not_halted", {31'd0, halted}, 32'd0);
      step();
      chk("drain_ext_halted", {31'd0, halted}, 32'd1);
      chk("drain_ext_cnt", {16'd0, stall_count}, 32'd6);

      // Reset mid-drain
      reset = 1; step(); reset = 0;
      halt_req = 1; step(); halt_req = 0; step();
      reset = 1; #1;
      chk("rst_in_drain", strb(), E_RST);
      step(); reset = 0; #1;
      chk("rst_drain_run", strb(), E_ALL);
      chk("rst_drain_halted", {31'd0, halted}, 32'd0);
      chk("rst_drain_cnt", {16'd0, stall_count}, 32'd0);

      // Timeout: 300 not-ready cycles
      mem_req = 1; mem_ready = 0;
      step();                      // RUN -> MEM_WAIT
      for (int i = 0; i < 254; i++) step();
      chk("tmo_before", {31'd0, mem_timeout}, 32'd0);
      step();
      chk("tmo_set", {31'd0, mem_timeout}, 32'd1);
      for (int i = 0; i < 44; i++) step();
      mem_ready = 1; #1;
      chk("tmo_ready", strb(), E_ALL);
      step(); idle(); #1;
      chk("tmo_run", strb(), E_ALL);
      chk("tmo_sticky", {31'd0, mem_timeout}, 32'd1);
      chk("tmo_cnt", {16'd0, stall_count}, 32'd300);
      reset = 1; step(); reset = 0; #1;
      chk("tmo_rst_clear", {31'd0, mem_timeout}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
